// File: rtl/ifetch_unit_pkg.sv
// Shared fetch-path types: instruction/address words, fetch FSM states, output packet.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package ifetch_unit_pkg;

    localparam int INST_ADDR_W = 12;
    localparam int INST_W      = 32;

    typedef logic [INST_ADDR_W-1:0] InstAddr;
    typedef logic [INST_W-1:0]      Inst;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        HOLD,
        FLUSH
    } FetchState;

    typedef struct packed {
        Inst     inst;
        InstAddr pc;
    } FetchPacket;

    // Word-address increment; wraps modulo 2^INST_ADDR_W by construction.
    function automatic InstAddr pc_advance(input InstAddr pc, input InstAddr step);
        return pc + step;
    endfunction

endpackage

// File: rtl/ifetch_unit.sv
// Instruction fetch front end: holds the PC, issues one ICache read at a time, buffers one result.
// Latency: a hit requested in cycle N is presented (o_valid) in cycle N+1; 1 instr/cycle sustained.
// Backpressure: i_ready low keeps o_inst/o_pc stable; no new read starts while the buffer is full.
//
// Ports:
//   i_clock, i_reset (async, active-low)
//   o_cache_addr/o_cache_rd -> ICache request; i_cache_inst/i_cache_busy/i_cache_hit <- ICache response
//   o_valid/i_ready/o_inst/o_pc -> decode handshake
//   i_redirect/i_redirect_pc   <- branch/jump/trap PC load
module ifetch_unit
    import ifetch_unit_pkg::*;
#(
    parameter InstAddr RESET_PC = InstAddr'(0),
    parameter InstAddr PC_STEP  = InstAddr'(1)
) (
    input  logic    i_clock,
    input  logic    i_reset,
    output InstAddr o_cache_addr,
    output logic    o_cache_rd,
    input  Inst     i_cache_inst,
    input  logic    i_cache_busy,
    input  logic    i_cache_hit,
    output logic    o_valid,
    input  logic    i_ready,
    output Inst     o_inst,
    output InstAddr o_pc,
    input  logic    i_redirect,
    input  InstAddr i_redirect_pc
);

    FetchState  state;
    InstAddr    pc;          // address of the current / next request
    InstAddr    redir_pc;    // target parked while a stale access drains
    logic       issued;      // read was asserted last cycle and has not completed
    logic       out_vld;
    FetchPacket out_q;

    logic buf_free;
    logic cache_done;
    logic accept;

    assign buf_free   = !out_vld || i_ready;
    assign accept     = out_vld && i_ready;
    assign cache_done = o_cache_rd && i_cache_hit && !i_cache_busy;

    // A new read in REQ only starts when its data has somewhere to land at
    // completion (buffer empty or draining this cycle). Once started it is
    // held regardless of i_ready: the buffer is necessarily empty by then,
    // because nothing else loads it while a read is outstanding.
    always_comb begin
        o_cache_rd = 1'b0;
        case (state)
            REQ:     o_cache_rd = issued || buf_free;
            FLUSH:   o_cache_rd = 1'b1;
            default: o_cache_rd = 1'b0;
        endcase
    end

    // In FLUSH pc still holds the stale in-flight address.
    assign o_cache_addr = pc;
    assign o_valid      = out_vld;
    assign o_inst       = out_q.inst;
    assign o_pc         = out_q.pc;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            redir_pc <= RESET_PC;
            issued   <= 1'b0;
            out_vld  <= 1'b0;
            out_q    <= '0;
        end else begin
            issued <= o_cache_rd && !cache_done;
            if (accept) begin
                out_vld <= 1'b0;
            end

            if (i_redirect) begin
                out_vld <= 1'b0;
                if (o_cache_rd && !cache_done) begin
                    // Cannot abandon the access; let it drain, remember where to go.
                    redir_pc <= i_redirect_pc;
                    state    <= FLUSH;
                end else begin
                    pc    <= i_redirect_pc;
                    state <= REQ;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (buf_free) begin
                            state <= REQ;
                        end
                    end
                    REQ: begin
                        if (cache_done) begin
                            out_q   <= '{inst: i_cache_inst, pc: pc};
                            out_vld <= 1'b1;
                            pc      <= pc_advance(pc, PC_STEP);
                            state   <= i_ready ? REQ : HOLD;
                        end
                    end
                    HOLD: begin
                        if (i_ready) begin
                            state <= REQ;
                        end
                    end
                    FLUSH: begin
                        if (cache_done) begin
                            pc    <= redir_pc;
                            state <= REQ;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
`timescale 1ns/1ps
module tb_ifetch_unit;
    import ifetch_unit_pkg::*;

    logic    i_clock;
    logic    i_reset;
    InstAddr o_cache_addr;
    logic    o_cache_rd;
    Inst     i_cache_inst;
    logic    i_cache_busy;
    logic    i_cache_hit;
    logic    o_valid;
    logic    i_ready;
    Inst     o_inst;
    InstAddr o_pc;
    logic    i_redirect;
    InstAddr i_redirect_pc;

    // second instance for PC wrap, fed by an always-hit cache
    InstAddr w_addr;
    logic    w_rd;
    logic    w_valid;
    Inst     w_inst;
    InstAddr w_pc;

    int checks = 0;
    int errors = 0;

    function automatic Inst inst_of(input InstAddr a);
        return {8'hC3, a ^ 12'h5A5, a};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    ifetch_unit dut (
        .i_clock(i_clock), .i_reset(i_reset),
        .o_cache_addr(o_cache_addr), .o_cache_rd(o_cache_rd),
        .i_cache_inst(i_cache_inst), .i_cache_busy(i_cache_busy), .i_cache_hit(i_cache_hit),
        .o_valid(o_valid), .i_ready(i_ready), .o_inst(o_inst), .o_pc(o_pc),
        .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc)
    );

    ifetch_unit #(.RESET_PC(12'hFFF), .PC_STEP(12'h001)) dut_w (
        .i_clock(i_clock), .i_reset(i_reset),
        .o_cache_addr(w_addr), .o_cache_rd(w_rd),
        .i_cache_inst(inst_of(w_addr)), .i_cache_busy(1'b0), .i_cache_hit(w_rd),
        .o_valid(w_valid), .i_ready(1'b1), .o_inst(w_inst), .o_pc(w_pc),
        .i_redirect(1'b0), .i_redirect_pc(12'h000)
    );

    initial i_clock = 1'b0;
    always #5 i_clock = ~i_clock;

    // ---------------- ICache model: per-address miss length ----------------
    int miss_len [0:4095];
    int wait_cnt;

    assign i_cache_inst = inst_of(o_cache_addr);
    assign i_cache_busy = o_cache_rd && (wait_cnt < miss_len[o_cache_addr]);
    assign i_cache_hit  = o_cache_rd && !(wait_cnt < miss_len[o_cache_addr]);

    always @(posedge i_clock or negedge i_reset) begin
        if (!i_reset)          wait_cnt <= 0;
        else if (i_cache_busy) wait_cnt <= wait_cnt + 1;
        else if (o_cache_rd)   wait_cnt <= 0;
    end

    // ---------------- Reference model / protocol monitor ----------------
    // Accepted instructions form a gap-free PC sequence restarting at every redirect target.
    InstAddr exp_pc;
    logic    pend;
    InstAddr pend_addr;
    logic    hold_prev;
    InstAddr prev_pc;
    Inst     prev_inst;
    int      n_acc = 0;

    always @(posedge i_clock) begin
        #4;
        if (!i_reset) begin
            exp_pc    = 12'h000;
            pend      = 1'b0;
            hold_prev = 1'b0;
        end else begin
            if (pend) begin
                chk("req_held_rd", o_cache_rd, 1);
                chk("req_held_addr", o_cache_addr, pend_addr);
            end
            if (hold_prev) begin
                chk("stall_vld", o_valid, 1);
                chk("stall_pc", o_pc, prev_pc);
                chk("stall_inst", o_inst, prev_inst);
            end
            if (o_valid && i_ready) begin
                chk("sb_pc", o_pc, exp_pc);
                chk("sb_inst", o_inst, inst_of(exp_pc));
                exp_pc = exp_pc + 12'h001;
                n_acc++;
            end
            if (i_redirect) exp_pc = i_redirect_pc;
            pend      = o_cache_rd && !(i_cache_hit && !i_cache_busy);
            pend_addr = o_cache_addr;
            hold_prev = o_valid && !i_ready && !i_redirect;
            prev_pc   = o_pc;
            prev_inst = o_inst;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic next_cycle();
        @(posedge i_clock);
        #1;
    endtask

    task automatic sample();
        #3;
    endtask

    // Leaves the caller at +1 of cycle 0 (first cycle out of reset, IDLE).
    task automatic do_reset();
        next_cycle();
        i_reset = 1'b0; i_redirect = 1'b0; i_ready = 1'b1; i_redirect_pc = '0;
        sample();
        chk("rst_rd", o_cache_rd, 0);
        chk("rst_addr", o_cache_addr, 12'h000);
        chk("rst_vld", o_valid, 0);
        chk("rst_w_addr", w_addr, 12'hFFF);
        next_cycle();
        i_reset = 1'b1;
    endtask

    typedef struct {
        logic    rst;
        logic    rdy;
        logic    exp_rd;
        InstAddr exp_addr;
        logic    exp_vld;
        InstAddr exp_pc;
    } vec_t;

    localparam int NV = 17;
    vec_t vec [NV];

    initial begin
        int n;
        int last_acc;
        int stall;
        int max_stall;
        InstAddr wq [$];

        i_reset = 1'b0; i_ready = 1'b1; i_redirect = 1'b0; i_redirect_pc = '0;
        for (int a = 0; a < 4096; a++) miss_len[a] = 0;

        // ---- table: streaming hits, then backpressure right after the first valid ----
        vec[0]  = '{1'b1, 1'b1, 1'b0, 12'h000, 1'b0, 12'h000};
        vec[1]  = '{1'b0, 1'b1, 1'b0, 12'h000, 1'b0, 12'h000};
        vec[2]  = '{1'b0, 1'b1, 1'b1, 12'h000, 1'b0, 12'h000};
        vec[3]  = '{1'b0, 1'b1, 1'b1, 12'h001, 1'b1, 12'h000};
        vec[4]  = '{1'b0, 1'b1, 1'b1, 12'h002, 1'b1, 12'h001};
        vec[5]  = '{1'b0, 1'b1, 1'b1, 12'h003, 1'b1, 12'h002};
        vec[6]  = '{1'b1, 1'b1, 1'b0, 12'h000, 1'b0, 12'h000};
        vec[7]  = '{1'b0, 1'b1, 1'b0, 12'h000, 1'b0, 12'h000};
        vec[8]  = '{1'b0, 1'b1, 1'b1, 12'h000, 1'b0, 12'h000};
        for (int k = 9; k < 14; k++)
            vec[k] = '{1'b0, 1'b0, 1'b0, 12'h001, 1'b1, 12'h000};
        vec[14] = '{1'b0, 1'b1, 1'b1, 12'h001, 1'b1, 12'h000};
        vec[15] = '{1'b0, 1'b1, 1'b1, 12'h002, 1'b1, 12'h001};
        vec[16] = '{1'b0, 1'b1, 1'b1, 12'h003, 1'b1, 12'h002};

        for (int k = 0; k < NV; k++) begin
            next_cycle();
            i_reset = !vec[k].rst;
            i_ready = vec[k].rdy;
            sample();
            chk($sformatf("vec%0d_rd", k), o_cache_rd, vec[k].exp_rd);
            chk($sformatf("vec%0d_addr", k), o_cache_addr, vec[k].exp_addr);
            chk($sformatf("vec%0d_vld", k), o_valid, vec[k].exp_vld);
            chk($sformatf("vec%0d_pc", k), o_pc, vec[k].exp_pc);
            chk($sformatf("vec%0d_inst", k), o_inst, vec[k].exp_vld ? inst_of(vec[k].exp_pc) : 32'h0);
        end

        // ---- miss at 0x010, 8 busy cycles ----
        do_reset();
        miss_len[12'h010] = 8;
        i_redirect = 1'b1; i_redirect_pc = 12'h010;
        sample();
        next_cycle();
        i_redirect = 1'b0;
        sample();
        n = 0;
        while (o_cache_rd && o_cache_addr == 12'h010 && i_cache_busy && n < 30) begin
            chk("miss_no_vld", o_valid, 0);
            n++;
            next_cycle();
            sample();
        end
        chk("miss_busy_cycles", n, 8);
        chk("miss_hit_addr", o_cache_addr, 12'h010);
        chk("miss_hit_rd", o_cache_rd, 1);
        next_cycle();
        sample();
        chk("miss_vld", o_valid, 1);
        chk("miss_pc", o_pc, 12'h010);
        chk("miss_next_addr", o_cache_addr, 12'h011);
        miss_len[12'h010] = 0;

        // ---- redirect to 0xF11 during a miss on 0x017 ----
        do_reset();
        miss_len[12'h017] = 6;
        i_redirect = 1'b1; i_redirect_pc = 12'h017;
        sample();
        next_cycle();
        i_redirect = 1'b0;
        sample();
        chk("flush_req_addr", o_cache_addr, 12'h017);
        next_cycle();
        i_redirect = 1'b1; i_redirect_pc = 12'hF11;
        sample();
        chk("flush_redir_rd", o_cache_rd, 1);
        next_cycle();
        i_redirect = 1'b0;
        sample();
        n = 0;
        while (i_cache_busy && n < 30) begin
            chk("flush_hold_rd", o_cache_rd, 1);
            chk("flush_hold_addr", o_cache_addr, 12'h017);
            chk("flush_no_vld", o_valid, 0);
            n++;
            next_cycle();
            sample();
        end
        chk("flush_done_addr", o_cache_addr, 12'h017);
        next_cycle();
        sample();
        chk("flush_next_addr", o_cache_addr, 12'hF11);
        chk("flush_next_vld", o_valid, 0);
        next_cycle();
        sample();
        chk("flush_first_vld", o_valid, 1);
        chk("flush_first_pc", o_pc, 12'hF11);
        miss_len[12'h017] = 0;

        // ---- redirect to 0x011 in the same cycle as a hit at 0x012 ----
        do_reset();
        i_redirect = 1'b1; i_redirect_pc = 12'h012;
        sample();
        next_cycle();
        i_redirect = 1'b1; i_redirect_pc = 12'h011;
        sample();
        chk("rdhit_addr", o_cache_addr, 12'h012);
        chk("rdhit_rd", o_cache_rd, 1);
        next_cycle();
        i_redirect = 1'b0;
        sample();
        chk("rdhit_vld_dropped", o_valid, 0);
        chk("rdhit_next_addr", o_cache_addr, 12'h011);
        next_cycle();
        sample();
        chk("rdhit_vld", o_valid, 1);
        chk("rdhit_pc", o_pc, 12'h011);

        // ---- PC wrap on the RESET_PC=0xFFF instance ----
        do_reset();
        for (int c = 0; c < 8; c++) begin
            sample();
            if (w_valid && wq.size() < 3) wq.push_back(w_pc);
            next_cycle();
        end
        chk("wrap_count", wq.size(), 3);
        if (wq.size() == 3) begin
            chk("wrap_pc0", wq[0], 12'hFFF);
            chk("wrap_pc1", wq[1], 12'h000);
            chk("wrap_pc2", wq[2], 12'h001);
        end

        // ---- async reset mid-miss ----
        do_reset();
        miss_len[12'h001] = 10;
        next_cycle();
        next_cycle();
        #1;
        chk("arst_pre_rd", o_cache_rd, 1);
        chk("arst_pre_vld", o_valid, 1);
        #1;
        i_reset = 1'b0;
        #1;
        chk("arst_rd", o_cache_rd, 0);
        chk("arst_vld", o_valid, 0);
        chk("arst_addr", o_cache_addr, 12'h000);
        chk("arst_pc", o_pc, 12'h000);
        chk("arst_inst", o_inst, 32'h0);
        miss_len[12'h001] = 0;

        // ---- randomized traffic against the scoreboard ----
        for (int a = 0; a < 4096; a++)
            miss_len[a] = ($urandom_range(0, 9) < 6) ? 0 : int'($urandom_range(1, 6));
        do_reset();
        last_acc = n_acc; stall = 0; max_stall = 0;
        for (int c = 0; c < 3000; c++) begin
            next_cycle();
            i_ready       = ($urandom_range(0, 3) != 0);
            i_redirect    = ($urandom_range(0, 15) == 0);
            i_redirect_pc = InstAddr'($urandom);
            if (n_acc != last_acc) begin
                last_acc = n_acc;
                stall = 0;
            end else begin
                stall++;
                if (stall > max_stall) max_stall = stall;
            end
        end
        chk("rand_progress", (max_stall <= 200), 1);
        chk("rand_accepted", (n_acc >= 300), 1);

        next_cycle();
        i_redirect = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
